// File: rtl/td4_pkg.sv
// Shared constants for the TD4 program loader: opcodes, field codes,
// error codes and loader FSM states.
package td4_pkg;

  localparam int ADDR_W = 4;
  localparam int WORD_W = 8;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [2:0] MN_ADD = 3'd0;
  localparam logic [2:0] MN_MOV = 3'd1;
  localparam logic [2:0] MN_IN  = 3'd2;
  localparam logic [2:0] MN_OUT = 3'd3;
  localparam logic [2:0] MN_JMP = 3'd4;
  localparam logic [2:0] MN_JNC = 3'd5;

  localparam logic       DST_A = 1'b0;
  localparam logic       DST_B = 1'b1;

  localparam logic [1:0] SRC_IMM = 2'd0;
  localparam logic [1:0] SRC_A   = 2'd1;
  localparam logic [1:0] SRC_B   = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_VERIFY   = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Host instruction stream, status and program memory write port of the loader.
interface td4_prog_loader_if;

  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_mn;
  logic       in_dst;
  logic [1:0] in_src;
  logic [3:0] in_imm;
  logic       in_last;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [7:0] prog_rdata;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [4:0] word_count;

  modport slave (
    input  start, in_valid, in_mn, in_dst, in_src, in_imm, in_last, prog_rdata,
    output in_ready, prog_we, prog_addr, prog_wdata, busy, done, error, err_code, word_count
  );

  modport master (
    output start, in_valid, in_mn, in_dst, in_src, in_imm, in_last, prog_rdata,
    input  in_ready, prog_we, prog_addr, prog_wdata, busy, done, error, err_code, word_count
  );

endinterface

// File: rtl/td4_insn_encode.sv
// Combinational TD4 assembler: symbolic fields -> {opcode, imm} word plus illegal flag.
module td4_insn_encode
  import td4_pkg::*;
(
  input  logic [2:0] mn_i,
  input  logic       dst_i,
  input  logic [1:0] src_i,
  input  logic [3:0] imm_i,
  output logic [7:0] word_o,
  output logic       illegal_o
);

  logic [3:0] op;
  logic       use_imm;

  always_comb begin
    op        = 4'b0000;
    use_imm   = 1'b0;
    illegal_o = 1'b0;
    case (mn_i)
      MN_ADD: begin
        if (src_i == SRC_IMM) begin
          op      = (dst_i == DST_B) ? OP_ADD_B_IM : OP_ADD_A_IM;
          use_imm = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      MN_MOV: begin
        if (src_i == SRC_IMM) begin
          op      = (dst_i == DST_B) ? OP_MOV_B_IM : OP_MOV_A_IM;
          use_imm = 1'b1;
        end else if (src_i == SRC_B && dst_i == DST_A) begin
          op = OP_MOV_A_B;
        end else if (src_i == SRC_A && dst_i == DST_B) begin
          op = OP_MOV_B_A;
        end else begin
          illegal_o = 1'b1;
        end
      end
      MN_IN: op = (dst_i == DST_B) ? OP_IN_B : OP_IN_A;
      MN_OUT: begin
        if (src_i == SRC_B) begin
          op = OP_OUT_B;
        end else if (src_i == SRC_IMM) begin
          op      = OP_OUT_IM;
          use_imm = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      MN_JMP, MN_JNC: begin
        if (src_i == SRC_IMM) begin
          op      = (mn_i == MN_JMP) ? OP_JMP : OP_JNC;
          use_imm = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Register-only forms carry a zero immediate field.
  assign word_o = {op, (use_imm ? imm_i : 4'h0)};

endmodule

// File: rtl/td4_prog_loader.sv
// Encodes a stream of TD4 instructions and writes them to program memory from address 0.
// Optional TD4_VERIFY_EN adds a read-back compare state after every write.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  td4_prog_loader_if.slave bus
);

  localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] word_q, word_d;
  logic       last_q, last_d;
  err_e       err_q, err_d;
  logic [7:0] enc_word;
  logic       enc_illegal;
  logic       commit;

  td4_insn_encode u_encode (
    .mn_i     (bus.in_mn),
    .dst_i    (bus.in_dst),
    .src_i    (bus.in_src),
    .imm_i    (bus.in_imm),
    .word_o   (enc_word),
    .illegal_o(enc_illegal)
  );

`ifndef TD4_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^bus.prog_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    commit  = 1'b0;
    if (bus.start) begin
      state_d = S_RUN;
      addr_d  = '0;
      cnt_d   = '0;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.in_valid) begin
            if (enc_illegal) begin
              state_d = S_ERROR;
              err_d   = ERR_ILLEGAL;
            end else begin
              word_d  = enc_word;
              last_d  = bus.in_last;
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          cnt_d = cnt_q + 5'd1;
`ifdef TD4_VERIFY_EN
          state_d = S_VERIFY;
`else
          commit = 1'b1;
`endif
        end
`ifdef TD4_VERIFY_EN
        S_VERIFY: begin
          if (bus.prog_rdata != word_q) begin
            state_d = S_ERROR;
            err_d   = ERR_VERIFY;
          end else begin
            commit = 1'b1;
          end
        end
`endif
        default: ;
      endcase
      // A stored word either finishes the program, overflows the memory or advances.
      if (commit) begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_ERROR;
          err_d   = ERR_OVERFLOW;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_RUN;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready   = (state_q == S_RUN) && !bus.start;
    bus.prog_we    = (state_q == S_WRITE);
    bus.prog_addr  = addr_q;
    bus.prog_wdata = word_q;
    bus.busy       = (state_q == S_RUN) || (state_q == S_WRITE) || (state_q == S_VERIFY);
    bus.done       = (state_q == S_DONE);
    bus.error      = (state_q == S_ERROR);
    bus.err_code   = err_q;
    bus.word_count = cnt_q;
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Scoreboard bench for td4_prog_loader: expected memory writes are queued by the
// driver and popped by a monitor on every prog_we; status is checked directly.
module tb_td4_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bad_rd = 1'b0;
  logic [7:0] mem [16];
  logic [11:0] exp_q [$];
  logic [3:0] exp_addr = 4'd0;
  int total = 0;
  int bad = 0;

  td4_prog_loader_if bus();

  td4_prog_loader #(.DEPTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_wdata;
  assign bus.prog_rdata = bad_rd ? 8'h00 : mem[bus.prog_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.prog_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {20'h0, bus.prog_addr, bus.prog_wdata}, 32'hFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("write_addr", bus.prog_addr, e[11:8]);
        chk("write_data", bus.prog_wdata, e[7:0]);
      end
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_addr = 4'd0;
  endtask

  task automatic send(input logic [2:0] mn, input logic dst, input logic [1:0] src,
                      input logic [3:0] imm, input logic last, input logic legal,
                      input logic [7:0] exp_word);
    bit ok = 0;
    bus.in_mn = mn; bus.in_dst = dst; bus.in_src = src; bus.in_imm = imm; bus.in_last = last;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) fail_now("accept_timeout");
    else if (legal) begin
      exp_q.push_back({exp_addr, exp_word});
      exp_addr = exp_addr + 4'd1;
    end
  endtask

  task automatic wait_end();
    bit ok = 0;
    for (int n = 0; n < 12 && !ok; n++) begin
      @(negedge clk);
      if (bus.done || bus.error) ok = 1;
    end
    if (!ok) fail_now("end_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  ill_mn  [4] = '{3'd1, 3'd6, 3'd3, 3'd4};
    logic        ill_dst [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  ill_src [4] = '{2'd1, 2'd0, 2'd1, 2'd2};
    logic [2:0]  p_mn  [6] = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd1, 3'd2};
    logic        p_dst [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  p_src [6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3};
    logic [3:0]  p_imm [6] = '{4'h7, 4'h2, 4'h3, 4'h9, 4'h4, 4'h8};
    logic [7:0]  p_exp [6] = '{8'h60, 8'h40, 8'h53, 8'hB9, 8'h10, 8'h20};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_mn = '0; bus.in_dst = 1'b0;
    bus.in_src = '0; bus.in_imm = '0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {bus.in_ready, bus.prog_we, bus.busy, bus.done, bus.error}, 0);
    chk("reset_data", {bus.err_code, bus.prog_addr, bus.prog_wdata, bus.word_count}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single instruction program
    do_start();
    @(negedge clk);
    chk("run_busy_ready", {bus.busy, bus.in_ready, bus.done}, 3'b110);
    @(posedge clk); #1;
    send(3'd1, 1'b0, 2'd0, 4'h5, 1'b1, 1'b1, 8'h35);
    wait_end();
    chk("t1_done", {bus.done, bus.error, bus.busy}, 3'b100);
    chk("t1_count", bus.word_count, 1);

    // Three instruction program
    do_start();
    chk("restart_clears_done", bus.done, 0);
    send(3'd0, 1'b0, 2'd0, 4'h1, 1'b0, 1'b1, 8'h01);
    send(3'd3, 1'b1, 2'd2, 4'hC, 1'b0, 1'b1, 8'h90);
    send(3'd4, 1'b1, 2'd0, 4'h0, 1'b1, 1'b1, 8'hF0);
    wait_end();
    chk("t2_done", {bus.done, bus.error}, 2'b10);
    chk("t2_count", bus.word_count, 3);
    chk("t2_addr", bus.prog_addr, 2);

    // Remaining encodings, register forms zero the immediate
    do_start();
    for (int i = 0; i < 6; i++) send(p_mn[i], p_dst[i], p_src[i], p_imm[i], (i == 5), 1'b1, p_exp[i]);
    wait_end();
    chk("t2b_done", {bus.done, bus.error}, 2'b10);
    chk("t2b_count", bus.word_count, 6);

    // Illegal instructions abort without writing
    for (int i = 0; i < 4; i++) begin
      do_start();
      send(ill_mn[i], ill_dst[i], ill_src[i], 4'h5, 1'b1, 1'b0, 8'h00);
      wait_end();
      chk("ill_error", {bus.error, bus.done, bus.busy, bus.in_ready}, 4'b1000);
      chk("ill_code", bus.err_code, 1);
      chk("ill_count", bus.word_count, 0);
    end
    do_start();
    chk("start_clears_error", {bus.error, bus.err_code}, 0);

    // Overflow after address 15 is written
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) send(3'd1, 1'b1, 2'd0, 4'(k), 1'b0, 1'b1, {4'h7, 4'(k)});
      else            send(3'd5, 1'b0, 2'd0, 4'(k), 1'b0, 1'b1, {4'hE, 4'(k)});
    end
    wait_end();
    chk("ovf_error", {bus.error, bus.done}, 2'b10);
    chk("ovf_code", bus.err_code, 2);
    chk("ovf_count", bus.word_count, 16);
    chk("ovf_addr", bus.prog_addr, 15);
    bus.in_mn = 3'd0; bus.in_src = 2'd0; bus.in_imm = 4'h1; bus.in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ovf_no_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    // start beats in_valid in RUN
    do_start();
    send(3'd0, 1'b0, 2'd0, 4'h2, 1'b0, 1'b1, 8'h02);
    @(posedge clk); #1;
    chk("t5_addr_adv", {bus.prog_addr, bus.word_count}, {4'd1, 5'd1});
    bus.in_mn = 3'd1; bus.in_dst = 1'b0; bus.in_src = 2'd0; bus.in_imm = 4'hA;
    bus.in_valid = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("t5_start_blocks_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.start = 1'b0; exp_addr = 4'd0;
    chk("t5_restart", {bus.prog_addr, bus.word_count, bus.busy, bus.prog_we}, {4'd0, 5'd0, 1'b1, 1'b0});

    // Reset in the middle of a load
    send(3'd0, 1'b0, 2'd0, 4'h3, 1'b0, 1'b1, 8'h03);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ctrl", {bus.in_ready, bus.prog_we, bus.busy, bus.done, bus.error}, 0);
    chk("midrst_data", {bus.err_code, bus.prog_addr, bus.prog_wdata, bus.word_count}, 0);
    bus.in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef TD4_VERIFY_EN
    // Read-back check
    do_start();
    send(3'd1, 1'b1, 2'd0, 4'hA, 1'b0, 1'b1, 8'h7A);
    send(3'd0, 1'b1, 2'd0, 4'h4, 1'b1, 1'b1, 8'h54);
    wait_end();
    chk("ver_ok", {bus.done, bus.error, bus.word_count}, {2'b10, 5'd2});
    do_start();
    bad_rd = 1'b1;
    send(3'd1, 1'b1, 2'd0, 4'hA, 1'b1, 1'b1, 8'h7A);
    wait_end();
    bad_rd = 1'b0;
    chk("ver_error", {bus.error, bus.done}, 2'b10);
    chk("ver_code", bus.err_code, 3);
    chk("ver_count", bus.word_count, 1);
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
